// File: rtl/multi_channel_gain.sv
// multi_channel_gain: per-channel Q(FRAC_BITS) volume, post-shift, saturation and mute
// between an upstream frame FIFO and a downstream frame FIFO.
module multi_channel_gain #(
    parameter int DATA_SIZE  = 32,
    parameter int NUM_CH     = 2,
    parameter int FRAC_BITS  = 10,
    parameter int GAIN_SHIFT = 14
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [NUM_CH*DATA_SIZE-1:0] volume,
    input  logic                        mute,
    input  logic                        sat_clear,
    input  logic [NUM_CH*DATA_SIZE-1:0] in,
    output logic                        in_rd_en,
    input  logic                        in_empty,
    output logic [NUM_CH*DATA_SIZE-1:0] gain_out,
    output logic                        out_wr_en,
    input  logic                        out_full,
    output logic                        sat_flag,
    output logic [NUM_CH-1:0]           sat_chan
);
    localparam int PW = 2 * DATA_SIZE;
    localparam int W  = PW + GAIN_SHIFT + 1;
    localparam logic signed [W-1:0] MAX_V = {{(W-DATA_SIZE+1){1'b0}}, {(DATA_SIZE-1){1'b1}}};
    localparam logic signed [W-1:0] MIN_V = {{(W-DATA_SIZE+1){1'b1}}, {(DATA_SIZE-1){1'b0}}};

    typedef enum logic [1:0] {READ, MULT, SCALE, WRITE} state_t;

    state_t state, next_state;
    logic rd_go, wr_go;
    logic [NUM_CH*DATA_SIZE-1:0] frame, res, res_next;
    logic [NUM_CH-1:0] satc, satc_next;
    logic signed [PW-1:0] prod [NUM_CH];

    // Divide by 2^FRAC_BITS rounding toward zero; W leaves headroom so -x never wraps.
    function automatic logic signed [W-1:0] trunc0(input logic signed [W-1:0] x);
        return x[W-1] ? -((-x) >>> FRAC_BITS) : x >>> FRAC_BITS;
    endfunction

    function automatic logic signed [W-1:0] scale(input logic signed [PW-1:0] p);
        logic signed [W-1:0] q;
        q = trunc0(W'(p));
        return trunc0(q <<< GAIN_SHIFT);
    endfunction

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= READ;
        else       state <= next_state;
    end

    always_comb begin
        rd_go = state == READ && !in_empty;
        wr_go = state == WRITE && !out_full;
        next_state = rd_go ? MULT : state == MULT ? SCALE : state == SCALE ? WRITE : wr_go ? READ : state;
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        logic signed [W-1:0] r;
        assign r = scale(prod[k]);
        assign satc_next[k] = r > MAX_V || r < MIN_V;
        assign res_next[k*DATA_SIZE +: DATA_SIZE] = r > MAX_V ? MAX_V[DATA_SIZE-1:0] :
                                                    r < MIN_V ? MIN_V[DATA_SIZE-1:0] : r[DATA_SIZE-1:0];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            in_rd_en  <= 1'b0;
            out_wr_en <= 1'b0;
            gain_out  <= '0;
            sat_flag  <= 1'b0;
            sat_chan  <= '0;
            frame     <= '0;
            res       <= '0;
            satc      <= '0;
            for (int k = 0; k < NUM_CH; k++) prod[k] <= '0;
        end else begin
            in_rd_en  <= rd_go;
            out_wr_en <= wr_go;
            if (rd_go) frame <= in;
            // volume is only sampled here, so later changes never touch the in-flight frame
            if (state == MULT)
                for (int k = 0; k < NUM_CH; k++)
                    prod[k] <= PW'($signed(frame[k*DATA_SIZE +: DATA_SIZE])) *
                               PW'($signed(volume[k*DATA_SIZE +: DATA_SIZE]));
            if (state == SCALE) begin
                res  <= res_next;
                satc <= satc_next;
            end
            if (wr_go) begin
                gain_out <= mute ? '0 : res;
                sat_chan <= satc;
            end
            sat_flag <= (sat_flag & ~sat_clear) | (wr_go & |satc);
        end
    end
endmodule

// File: tb/tb_multi_channel_gain.sv
// tb_multi_channel_gain: table-driven vectors plus backpressure, mute, volume, sat_clear
// and mid-frame reset sequences, checked through an expected-output queue.
module tb_multi_channel_gain;
    localparam int DS = 32;
    localparam int NC = 2;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic [NC*DS-1:0] volume = '0;
    logic mute = 1'b0;
    logic sat_clear = 1'b0;
    logic [NC*DS-1:0] in_data;
    logic in_rd_en, in_empty, out_wr_en, sat_flag;
    logic out_full = 1'b0;
    logic [NC*DS-1:0] gain_out;
    logic [NC-1:0] sat_chan;

    typedef struct { logic [63:0] data; logic [1:0] satc; } exp_t;
    typedef struct { logic [31:0] i0, i1, v0, v1, e0, e1; logic [1:0] s; } vec_t;

    exp_t exp_q[$];
    logic [63:0] src[$];
    int rd_idx = 0;
    int checks = 0;
    int fails = 0;

    multi_channel_gain dut (
        .clock(clock), .reset(reset), .volume(volume), .mute(mute), .sat_clear(sat_clear),
        .in(in_data), .in_rd_en(in_rd_en), .in_empty(in_empty), .gain_out(gain_out),
        .out_wr_en(out_wr_en), .out_full(out_full), .sat_flag(sat_flag), .sat_chan(sat_chan)
    );

    always #5 clock = ~clock;

    // First-word-fall-through upstream FIFO model
    assign in_empty = rd_idx >= src.size();
    assign in_data  = in_empty ? '0 : src[rd_idx];
    always @(posedge clock) if (in_rd_en) rd_idx <= rd_idx + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic push(input logic [31:0] i1, input logic [31:0] i0, input logic [31:0] e1,
                        input logic [31:0] e0, input logic [1:0] s, input bit expect_out);
        src.push_back({i1, i0});
        if (expect_out) exp_q.push_back('{{e1, e0}, s});
    endtask

    task automatic check_write(input string name);
        exp_t e;
        if (exp_q.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL %s: unexpected write of %h", name, gain_out);
        end else begin
            e = exp_q.pop_front();
            check({name, ".data"}, gain_out, e.data);
            check({name, ".sat_chan"}, 64'(sat_chan), 64'(e.satc));
        end
    endtask

    task automatic wait_rd(input string name);
        int n = 0;
        do begin @(negedge clock); n++; end while (!in_rd_en && n < 40);
        if (!in_rd_en) begin
            checks++;
            fails++;
            $display("FAIL %s: timeout waiting for in_rd_en", name);
        end
    endtask

    task automatic wait_write(input string name, output int n);
        n = 0;
        do begin @(negedge clock); n++; end while (!out_wr_en && n < 40);
        if (out_wr_en) check_write(name);
        else begin
            checks++;
            fails++;
            $display("FAIL %s: timeout waiting for out_wr_en", name);
        end
    endtask

    initial begin
        vec_t vt[10];
        int n;
        int rd_cnt;
        int wr_cnt;
        bit sf_m;
        vt[0] = '{1000, -1000, 512, 512, 8000, -8000, 2'b00};
        vt[1] = '{-1500, -3, 1, 1, -16, 0, 2'b00};
        vt[2] = '{1500, 3, 1, 1, 16, 0, 2'b00};
        vt[3] = '{-1000, 2000, -512, 64, 8000, 2000, 2'b00};
        vt[4] = '{-1023, -1024, 1, 1, 0, -16, 2'b00};
        vt[5] = '{32'h07FF_FFFF, 32'hF800_0000, 1024, 1024, 32'h7FFF_FFF0, 32'h8000_0000, 2'b00};
        vt[6] = '{32'h4000_0000, 32'hC000_0000, 32'h0010_0000, 32'h0010_0000,
                  32'h7FFF_FFFF, 32'h8000_0000, 2'b11};
        vt[7] = '{32'h4000_0000, 5, 32'h0010_0000, 1024, 32'h7FFF_FFFF, 80, 2'b01};
        vt[8] = '{32'h0800_0000, 32'hF7FF_FFFF, 1024, 1024, 32'h7FFF_FFFF, 32'h8000_0000, 2'b11};
        vt[9] = '{32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h7FFF_FFFF,
                  32'h7FFF_FFFF, 32'h8000_0000, 2'b11};
        sf_m = 1'b0;

        repeat (3) @(negedge clock);
        check("reset.in_rd_en", 64'(in_rd_en), 0);
        check("reset.out_wr_en", 64'(out_wr_en), 0);
        check("reset.gain_out", gain_out, 0);
        check("reset.sat_flag", 64'(sat_flag), 0);
        check("reset.sat_chan", 64'(sat_chan), 0);
        reset = 1'b0;
        @(negedge clock);

        for (int i = 0; i < 10; i++) begin
            volume = {vt[i].v1, vt[i].v0};
            push(vt[i].i1, vt[i].i0, vt[i].e1, vt[i].e0, vt[i].s, 1'b1);
            wait_rd($sformatf("vec%0d", i));
            wait_write($sformatf("vec%0d", i), n);
            check($sformatf("vec%0d.latency", i), 64'(n), 3);
            sf_m = sf_m | (|vt[i].s);
            check($sformatf("vec%0d.sat_flag", i), 64'(sat_flag), 64'(sf_m));
        end

        // sticky flag holds until cleared
        repeat (5) @(negedge clock);
        check("sticky.hold", 64'(sat_flag), 1);
        sat_clear = 1'b1;
        @(negedge clock);
        sat_clear = 1'b0;
        check("sticky.clear", 64'(sat_flag), 0);

        // clear coincident with a saturating write: set wins
        sat_clear = 1'b1;
        volume = {32'h0010_0000, 32'h0010_0000};
        push(32'hC000_0000, 32'h4000_0000, 32'h8000_0000, 32'h7FFF_FFFF, 2'b11, 1'b1);
        wait_rd("setwins");
        wait_write("setwins", n);
        check("setwins.flag", 64'(sat_flag), 1);
        sat_clear = 1'b0;
        @(negedge clock);
        check("setwins.hold", 64'(sat_flag), 1);
        sat_clear = 1'b1;
        @(negedge clock);
        sat_clear = 1'b0;
        check("setwins.clear", 64'(sat_flag), 0);

        // mute zeroes data but saturation is still recorded
        mute = 1'b1;
        push(32'hC000_0000, 32'h4000_0000, 0, 0, 2'b11, 1'b1);
        wait_rd("mute");
        wait_write("mute", n);
        check("mute.sat_flag", 64'(sat_flag), 1);
        mute = 1'b0;

        // volume change after MULT only affects the next frame
        volume = {32'd512, 32'd512};
        push(-1000, 1000, -8000, 8000, 2'b00, 1'b1);
        wait_rd("volchg0");
        @(negedge clock);
        volume = {32'd256, 32'd1024};
        wait_write("volchg0", n);
        push(-1000, 1000, -4000, 16000, 2'b00, 1'b1);
        wait_rd("volchg1");
        wait_write("volchg1", n);

        // backpressure: stall in WRITE, then drain four frames in order
        out_full = 1'b1;
        volume = {32'd1024, 32'd1024};
        for (int k = 1; k <= 4; k++) push(-10 * k, 10 * k, -160 * k, 160 * k, 2'b00, 1'b1);
        wait_rd("bp");
        rd_cnt = 0;
        wr_cnt = 0;
        repeat (12) begin
            @(negedge clock);
            rd_cnt += int'(in_rd_en);
            wr_cnt += int'(out_wr_en);
        end
        check("bp.no_read", 64'(rd_cnt), 0);
        check("bp.no_write", 64'(wr_cnt), 0);
        check("bp.gain_hold", gain_out, {32'hFFFF_F060, 32'h0000_3E80});
        out_full = 1'b0;
        @(negedge clock);
        check("bp.release_write", 64'(out_wr_en), 1);
        if (out_wr_en) check_write("bp0");
        for (int k = 1; k < 4; k++) begin
            wait_write($sformatf("bp%0d", k), n);
            check($sformatf("bp%0d.period", k), 64'(n), 4);
        end

        // reset during SCALE discards the frame
        volume = {32'd512, 32'd512};
        push(-1000, 1000, 0, 0, 2'b00, 1'b0);
        wait_rd("rst");
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("rst.out_wr_en", 64'(out_wr_en), 0);
        check("rst.in_rd_en", 64'(in_rd_en), 0);
        check("rst.gain_out", gain_out, 0);
        check("rst.sat_flag", 64'(sat_flag), 0);
        check("rst.sat_chan", 64'(sat_chan), 0);
        reset = 1'b0;
        wr_cnt = 0;
        repeat (8) begin
            @(negedge clock);
            wr_cnt += int'(out_wr_en);
        end
        check("rst.no_write", 64'(wr_cnt), 0);
        push(3, 1500, 16, 12000, 2'b00, 1'b1);
        wait_rd("postrst");
        wait_write("postrst", n);
        check("postrst.latency", 64'(n), 3);

        check("scoreboard.empty", 64'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
